// File: rtl/sap_pkg.sv
// Shared definitions for the SAP controller: opcodes, T-state encoding and
// control-word bit positions used by the controller, datapath and bench.
package sap_pkg;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int T_STATES = 6;
    localparam int T1_IDX   = 0;
    localparam int T2_IDX   = 1;
    localparam int T3_IDX   = 2;
    localparam int T4_IDX   = 3;
    localparam int T5_IDX   = 4;
    localparam int T6_IDX   = 5;

    // Control word layout, MSB first: pc_inc .. out_load.
    localparam int CW_W        = 12;
    localparam int CW_PC_INC   = 11;
    localparam int CW_PC_SEND  = 10;
    localparam int CW_MAR_LOAD = 9;
    localparam int CW_RAM_SEND = 8;
    localparam int CW_IR_LOAD  = 7;
    localparam int CW_IR_SEND  = 6;
    localparam int CW_A_LOAD   = 5;
    localparam int CW_A_SEND   = 4;
    localparam int CW_B_LOAD   = 3;
    localparam int CW_ALU_SUB  = 2;
    localparam int CW_ALU_SEND = 1;
    localparam int CW_OUT_LOAD = 0;

    // The all-zero code doubles as the halted state so o_t_state reads 0 there.
    typedef enum logic [T_STATES-1:0] {
        ST_HALT = 6'b000000,
        ST_T1   = 6'b000001,
        ST_T2   = 6'b000010,
        ST_T3   = 6'b000100,
        ST_T4   = 6'b001000,
        ST_T5   = 6'b010000,
        ST_T6   = 6'b100000
    } t_state_e;

    function automatic logic [CW_W-1:0] cw_only(input int pos);
        logic [CW_W-1:0] w;
        w      = '0;
        w[pos] = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/sap_ring_counter.sv
// One-hot T1..T6 ring with gated advance, early return to T1, and a sticky
// halted state left only through reset.
module sap_ring_counter
    import sap_pkg::*;
(
    input  logic                clock,
    input  logic                reset_n,
    input  logic                advance,
    input  logic                early_return,
    input  logic                halt,
    output logic [T_STATES-1:0] t_state,
    output logic                halted
);

    t_state_e state;
    t_state_e state_next;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_T1;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (advance && (state != ST_HALT)) begin
            if (halt) begin
                state_next = ST_HALT;
            end else if (early_return) begin
                state_next = ST_T1;
            end else begin
                case (state)
                    ST_T1:   state_next = ST_T2;
                    ST_T2:   state_next = ST_T3;
                    ST_T3:   state_next = ST_T4;
                    ST_T4:   state_next = ST_T5;
                    ST_T5:   state_next = ST_T6;
                    ST_T6:   state_next = ST_T1;
                    default: state_next = ST_T1;
                endcase
            end
        end
    end

    assign t_state = state;
    assign halted  = (state == ST_HALT);

endmodule

// File: rtl/sap_controller.sv
// SAP controller-sequencer: paces the T-ring (free-run or single-step) and
// decodes T-state plus opcode into the datapath load/send strobes.
module sap_controller
    import sap_pkg::*;
#(
    parameter int OPCODE_W        = 4,
    parameter int SKIP_NOP_STATES = 0
) (
    input  logic                i_clock,
    input  logic                i_reset_n,
    input  logic [OPCODE_W-1:0] i_opcode,
    input  logic                i_step_mode,
    input  logic                i_step,
    output logic                o_pc_inc,
    output logic                o_pc_send,
    output logic                o_mar_load,
    output logic                o_ram_send,
    output logic                o_ir_load,
    output logic                o_ir_send,
    output logic                o_a_load,
    output logic                o_a_send,
    output logic                o_b_load,
    output logic                o_alu_sub,
    output logic                o_alu_send,
    output logic                o_out_load,
    output logic [T_STATES-1:0] o_t_state,
    output logic                o_halted
);

    logic                step_prev;
    logic                advance;
    logic                early_return;
    logic                halt_req;
    logic [T_STATES-1:0] t_state;
    logic                halted;
    logic [CW_W-1:0]     cw;

    logic is_lda, is_add, is_sub, is_out, is_hlt, is_defined;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            step_prev <= 1'b0;
        end else begin
            step_prev <= i_step;
        end
    end

    // In step mode only a fresh rising edge of i_step moves the ring.
    assign advance = i_step_mode ? (i_step & ~step_prev) : 1'b1;

    assign is_lda     = (i_opcode == OPCODE_W'(OP_LDA));
    assign is_add     = (i_opcode == OPCODE_W'(OP_ADD));
    assign is_sub     = (i_opcode == OPCODE_W'(OP_SUB));
    assign is_out     = (i_opcode == OPCODE_W'(OP_OUT));
    assign is_hlt     = (i_opcode == OPCODE_W'(OP_HLT));
    assign is_defined = is_lda | is_add | is_sub | is_out | is_hlt;

    assign halt_req = t_state[T4_IDX] & is_hlt;

    always_comb begin
        early_return = 1'b0;
        if (SKIP_NOP_STATES != 0) begin
            early_return = (t_state[T3_IDX] & ~is_defined)
                         | (t_state[T4_IDX] & is_out)
                         | (t_state[T5_IDX] & is_lda);
        end
    end

    sap_ring_counter u_ring (
        .clock        (i_clock),
        .reset_n      (i_reset_n),
        .advance      (advance),
        .early_return (early_return),
        .halt         (halt_req),
        .t_state      (t_state),
        .halted       (halted)
    );

    // Halted state is all-zero, so no T-bit is set and every strobe stays low.
    always_comb begin
        cw = '0;
        if (t_state[T1_IDX]) begin
            cw = cw_only(CW_PC_SEND) | cw_only(CW_MAR_LOAD);
        end
        if (t_state[T2_IDX]) begin
            cw = cw_only(CW_PC_INC);
        end
        if (t_state[T3_IDX]) begin
            cw = cw_only(CW_RAM_SEND) | cw_only(CW_IR_LOAD);
        end
        if (t_state[T4_IDX]) begin
            if (is_lda || is_add || is_sub) begin
                cw = cw_only(CW_IR_SEND) | cw_only(CW_MAR_LOAD);
            end else if (is_out) begin
                cw = cw_only(CW_A_SEND) | cw_only(CW_OUT_LOAD);
            end
        end
        if (t_state[T5_IDX]) begin
            if (is_lda) begin
                cw = cw_only(CW_RAM_SEND) | cw_only(CW_A_LOAD);
            end else if (is_add || is_sub) begin
                cw = cw_only(CW_RAM_SEND) | cw_only(CW_B_LOAD);
            end
        end
        if (t_state[T6_IDX]) begin
            if (is_add) begin
                cw = cw_only(CW_ALU_SEND) | cw_only(CW_A_LOAD);
            end else if (is_sub) begin
                cw = cw_only(CW_ALU_SEND) | cw_only(CW_A_LOAD) | cw_only(CW_ALU_SUB);
            end
        end
        // The ring already reads T1 during reset; keep its fetch strobes off.
        if (!i_reset_n) begin
            cw = '0;
        end
    end

    assign o_pc_inc   = cw[CW_PC_INC];
    assign o_pc_send  = cw[CW_PC_SEND];
    assign o_mar_load = cw[CW_MAR_LOAD];
    assign o_ram_send = cw[CW_RAM_SEND];
    assign o_ir_load  = cw[CW_IR_LOAD];
    assign o_ir_send  = cw[CW_IR_SEND];
    assign o_a_load   = cw[CW_A_LOAD];
    assign o_a_send   = cw[CW_A_SEND];
    assign o_b_load   = cw[CW_B_LOAD];
    assign o_alu_sub  = cw[CW_ALU_SUB];
    assign o_alu_send = cw[CW_ALU_SEND];
    assign o_out_load = cw[CW_OUT_LOAD];
    assign o_t_state  = t_state;
    assign o_halted   = halted;

endmodule

// File: tb/tb_sap_controller.sv
// Directed bench for sap_controller: one instance with default parameters and
// one with SKIP_NOP_STATES=1, driven from a single linear stimulus sequence.
module tb_sap_controller;

    localparam logic [11:0] PC_INC   = 12'h800;
    localparam logic [11:0] PC_SEND  = 12'h400;
    localparam logic [11:0] MAR_LOAD = 12'h200;
    localparam logic [11:0] RAM_SEND = 12'h100;
    localparam logic [11:0] IR_LOAD  = 12'h080;
    localparam logic [11:0] IR_SEND  = 12'h040;
    localparam logic [11:0] A_LOAD   = 12'h020;
    localparam logic [11:0] A_SEND   = 12'h010;
    localparam logic [11:0] B_LOAD   = 12'h008;
    localparam logic [11:0] ALU_SUB  = 12'h004;
    localparam logic [11:0] ALU_SEND = 12'h002;
    localparam logic [11:0] OUT_LOAD = 12'h001;
    localparam logic [11:0] NONE     = 12'h000;
    localparam logic [11:0] SENDS    = PC_SEND | RAM_SEND | IR_SEND | A_SEND | ALU_SEND;

    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;
    localparam logic [5:0] TH = 6'b000000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rst_s_n;
    logic [3:0] opcode;
    logic       step_mode;
    logic       step;

    logic [11:0] cw_m, cw_s;
    logic [5:0]  t_m, t_s;
    logic        h_m, h_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sap_controller dut (
        .i_clock(clk), .i_reset_n(rst_n), .i_opcode(opcode),
        .i_step_mode(step_mode), .i_step(step),
        .o_pc_inc(cw_m[11]), .o_pc_send(cw_m[10]), .o_mar_load(cw_m[9]),
        .o_ram_send(cw_m[8]), .o_ir_load(cw_m[7]), .o_ir_send(cw_m[6]),
        .o_a_load(cw_m[5]), .o_a_send(cw_m[4]), .o_b_load(cw_m[3]),
        .o_alu_sub(cw_m[2]), .o_alu_send(cw_m[1]), .o_out_load(cw_m[0]),
        .o_t_state(t_m), .o_halted(h_m)
    );

    sap_controller #(.OPCODE_W(4), .SKIP_NOP_STATES(1)) dut_s (
        .i_clock(clk), .i_reset_n(rst_s_n), .i_opcode(opcode),
        .i_step_mode(step_mode), .i_step(step),
        .o_pc_inc(cw_s[11]), .o_pc_send(cw_s[10]), .o_mar_load(cw_s[9]),
        .o_ram_send(cw_s[8]), .o_ir_load(cw_s[7]), .o_ir_send(cw_s[6]),
        .o_a_load(cw_s[5]), .o_a_send(cw_s[4]), .o_b_load(cw_s[3]),
        .o_alu_sub(cw_s[2]), .o_alu_send(cw_s[1]), .o_out_load(cw_s[0]),
        .o_t_state(t_s), .o_halted(h_s)
    );

    // Single bus driver: never more than one send strobe, checked every cycle.
    always @(negedge clk) begin
        checks++;
        assert ($countones(cw_m & SENDS) <= 1 && $countones(cw_s & SENDS) <= 1) else begin
            errors++;
            $error("FAIL one_hot_send observed main=%h skip=%h required at most one send", cw_m & SENDS, cw_s & SENDS);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input bit sel, input string tag, input logic [11:0] ecw,
                       input logic [5:0] et, input logic eh);
        logic [18:0] obs;
        logic [18:0] exp_v;
        #1;
        obs   = sel ? {cw_s, t_s, h_s} : {cw_m, t_m, h_m};
        exp_v = {ecw, et, eh};
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed cw=%h t=%b h=%b required cw=%h t=%b h=%b",
                   tag, obs[18:7], obs[6:1], obs[0], ecw, et, eh);
        end
    endtask

    task automatic instr(input bit sel, input string nm, input logic [3:0] op,
                         input logic [11:0] c4, input logic [11:0] c5, input logic [11:0] c6);
        opcode = op;
        chk(sel, {nm, "_t1"}, PC_SEND | MAR_LOAD, T1, 1'b0); cyc();
        chk(sel, {nm, "_t2"}, PC_INC, T2, 1'b0);             cyc();
        chk(sel, {nm, "_t3"}, RAM_SEND | IR_LOAD, T3, 1'b0); cyc();
        chk(sel, {nm, "_t4"}, c4, T4, 1'b0);                 cyc();
        chk(sel, {nm, "_t5"}, c5, T5, 1'b0);                 cyc();
        chk(sel, {nm, "_t6"}, c6, T6, 1'b0);                 cyc();
    endtask

    initial begin
        rst_n = 1'b0; rst_s_n = 1'b0; opcode = 4'h0; step_mode = 1'b0; step = 1'b0;

        // Reset held three cycles, then release.
        cyc(); cyc(); cyc();
        chk(0, "reset_hold", NONE, T1, 1'b0);
        rst_n = 1'b1;
        chk(0, "reset_release_t1", PC_SEND | MAR_LOAD, T1, 1'b0);
        cyc();

        // Wait: first cycle after release already advanced; re-align to T1.
        rst_n = 1'b0; cyc(); rst_n = 1'b1;

        instr(0, "lda", 4'h0, IR_SEND | MAR_LOAD, RAM_SEND | A_LOAD, NONE);
        instr(0, "add", 4'h1, IR_SEND | MAR_LOAD, RAM_SEND | B_LOAD, ALU_SEND | A_LOAD);
        instr(0, "sub", 4'h2, IR_SEND | MAR_LOAD, RAM_SEND | B_LOAD, ALU_SUB | ALU_SEND | A_LOAD);
        instr(0, "out", 4'hE, A_SEND | OUT_LOAD, NONE, NONE);
        instr(0, "undef", 4'h7, NONE, NONE, NONE);
        chk(0, "wrap_t1", PC_SEND | MAR_LOAD, T1, 1'b0);

        // Reset in T5 of ADD.
        opcode = 4'h1;
        cyc(); cyc(); cyc(); cyc();
        chk(0, "add_mid_t5", RAM_SEND | B_LOAD, T5, 1'b0);
        rst_n = 1'b0;
        chk(0, "mid_reset_same_cycle", NONE, T1, 1'b0);
        cyc();
        chk(0, "mid_reset_held", NONE, T1, 1'b0);
        rst_n = 1'b1;
        chk(0, "mid_reset_release", PC_SEND | MAR_LOAD, T1, 1'b0);

        // HLT: fetch normally, halt after T4, ignore step, leave via reset.
        opcode = 4'hF;
        cyc(); chk(0, "hlt_t2", PC_INC, T2, 1'b0);
        cyc(); chk(0, "hlt_t3", RAM_SEND | IR_LOAD, T3, 1'b0);
        cyc(); chk(0, "hlt_t4", NONE, T4, 1'b0);
        cyc(); chk(0, "hlt_halted", NONE, TH, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step      = i[0];
            step_mode = i[1];
            cyc();
            chk(0, "hlt_stay", NONE, TH, 1'b1);
        end
        step = 1'b0; step_mode = 1'b0;
        rst_n = 1'b0;
        chk(0, "hlt_reset", NONE, T1, 1'b0);
        cyc();
        rst_n = 1'b1;
        chk(0, "hlt_release", PC_SEND | MAR_LOAD, T1, 1'b0);

        // Step mode: held-high step gives a single advance.
        step_mode = 1'b1; opcode = 4'h1;
        cyc(); chk(0, "step_idle", PC_SEND | MAR_LOAD, T1, 1'b0);
        step = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk(0, "step_held", PC_INC, T2, 1'b0);
        end
        step = 1'b0;
        cyc(); chk(0, "step_low", PC_INC, T2, 1'b0);

        rst_n = 1'b0; cyc(); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step = 1'b1; cyc();
            step = 1'b0; cyc();
        end
        chk(0, "step_pulses_t4", IR_SEND | MAR_LOAD, T4, 1'b0);
        step_mode = 1'b0;
        cyc(); chk(0, "mode_switch_t5", RAM_SEND | B_LOAD, T5, 1'b0);

        // Early return to T1 with SKIP_NOP_STATES=1.
        opcode = 4'h0; rst_s_n = 1'b1;
        chk(1, "skip_lda_t1", PC_SEND | MAR_LOAD, T1, 1'b0);
        cyc(); cyc(); cyc();
        chk(1, "skip_lda_t4", IR_SEND | MAR_LOAD, T4, 1'b0);
        cyc(); chk(1, "skip_lda_t5", RAM_SEND | A_LOAD, T5, 1'b0);
        cyc(); chk(1, "skip_lda_back_t1", PC_SEND | MAR_LOAD, T1, 1'b0);

        opcode = 4'hE;
        cyc(); cyc(); cyc();
        chk(1, "skip_out_t4", A_SEND | OUT_LOAD, T4, 1'b0);
        cyc(); chk(1, "skip_out_back_t1", PC_SEND | MAR_LOAD, T1, 1'b0);

        opcode = 4'h5;
        cyc(); cyc();
        chk(1, "skip_undef_t3", RAM_SEND | IR_LOAD, T3, 1'b0);
        cyc(); chk(1, "skip_undef_back_t1", PC_SEND | MAR_LOAD, T1, 1'b0);

        opcode = 4'h2;
        cyc(); cyc(); cyc(); cyc(); cyc();
        chk(1, "skip_sub_t6", ALU_SUB | ALU_SEND | A_LOAD, T6, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
